// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed byte stream into 16-bit words for instruction memory.
// Latency: one write strobe the cycle after each lo data byte; cpu_run follows the last write.
// Backpressure: i_in_ready low in DONE/ERROR and during each write cycle (one bubble per word).
//
// Stream: header N (hi, lo), N data words (hi, lo), and a checksum word when
// LOADER_CHECKSUM_EN is defined (16-bit running sum over the data words only).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_reload       synchronous restart; wins over a coincident byte transfer
//   i_in_data      host byte
//   i_in_valid     host byte valid
//   o_in_ready     loader accepts a byte this cycle
//   o_imem_we      one-cycle instruction memory write strobe
//   o_imem_addr    write address (holds after the strobe)
//   o_imem_wdata   write data (holds after the strobe)
//   o_cpu_run      image complete, CPU may run
//   o_load_err     sticky error flag (oversized header or checksum mismatch)
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_reload,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_cpu_run,
  output logic              o_load_err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LP_AFTER_DATA = S_CHK_HI;
`else
  localparam state_t LP_AFTER_DATA = S_DONE;
`endif

  // Largest legal word count: the full memory depth.
  localparam logic [16:0] LP_MAX_N = 17'd1 << ADDR_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_live;     // low only until the first edge after reset
  logic              r_we;
  logic [7:0]        r_hi;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_addr;     // next address to write
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       r_sum;
`endif

  logic              w_accept;
  logic              w_loading;
  logic [15:0]       w_word;
  logic [16:0]       w_word17;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_last;
  logic              w_wr;
  logic              w_take_hi;
  logic              w_take_n;

  assign w_word    = {r_hi, i_in_data};
  assign w_word17  = {1'b0, w_word};
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == r_n);
  assign w_loading = (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_accept  = i_in_valid && o_in_ready;

  assign o_in_ready   = r_live && w_loading && !r_we;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_wr_addr;
  assign o_imem_wdata = r_wr_data;
  // Held off while the final write strobe is still in flight.
  assign o_cpu_run    = (r_state == S_DONE) && !r_we;
  assign o_load_err   = (r_state == S_ERROR);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_HDR_HI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_take_hi   = 1'b0;
    w_take_n    = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_HDR_HI: begin
          w_take_hi   = 1'b1;
          w_state_nxt = S_HDR_LO;
        end
        S_HDR_LO: begin
          w_take_n = 1'b1;
          if (w_word == 16'd0) begin
            w_state_nxt = LP_AFTER_DATA;
          end else if (w_word17 > LP_MAX_N) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          w_take_hi   = 1'b1;
          w_state_nxt = S_DATA_LO;
        end
        S_DATA_LO: begin
          w_wr        = 1'b1;
          w_state_nxt = w_last ? LP_AFTER_DATA : S_DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK_HI: begin
          w_take_hi   = 1'b1;
          w_state_nxt = S_CHK_LO;
        end
        S_CHK_LO: begin
          w_state_nxt = (w_word == r_sum) ? S_DONE : S_ERROR;
        end
`endif
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
    // Reload drops any byte transferring this cycle.
    if (i_reload) begin
      w_state_nxt = S_HDR_HI;
      w_wr        = 1'b0;
      w_take_hi   = 1'b0;
      w_take_n    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_live    <= 1'b0;
      r_we      <= 1'b0;
      r_hi      <= 8'd0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= 16'd0;
`endif
    end else begin
      r_live <= 1'b1;
      r_we   <= w_wr;
      if (i_reload) begin
        r_cnt  <= '0;
        r_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= 16'd0;
`endif
      end else begin
        if (w_take_hi) begin
          r_hi <= i_in_data;
        end
        if (w_take_n) begin
          r_n <= w_word17[ADDR_W:0];
        end
        if (w_wr) begin
          r_wr_addr <= r_addr;
          r_wr_data <= w_word;
          // Wraps to 0 after a full-depth image; nothing is written there.
          r_addr    <= r_addr + 1'b1;
          r_cnt     <= w_cnt_inc;
`ifdef LOADER_CHECKSUM_EN
          r_sum     <= r_sum + w_word;
`endif
        end
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits between a byte-wide host link and the single-cycle 16-bit CPU's instruction memory write port. It receives a length-prefixed stream of bytes and assembles them into 16-bit words, high byte first. Each word is written to consecutive instruction-memory addresses starting at 0. The block holds the CPU out of execution until the image is complete, then asserts `cpu_run`.

## Interface
- `ADDR_W`, default 8: instruction memory address width; depth = 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reload`  in  1  synchronous pulse; aborts or restarts a load.
- `in_data`  in  8  byte from the host link.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  16  write data.
- `cpu_run`  out  1  image complete; the CPU may leave reset.
- `load_err`  out  1  sticky error flag.

## Operation
- A byte transfers only when `in_valid && in_ready` is true at a rising edge.
- Stream format:
  - header word N (hi byte, lo byte);
  - then N data words, each hi byte then lo byte;
  - with `LOADER_CHECKSUM_EN`, then a checksum word (hi, lo).
- States and transitions:
  - HDR_HI → HDR_LO.
  - HDR_LO:
    - N = 0 → DONE (or CHK_HI when `LOADER_CHECKSUM_EN` is defined).
    - N > 2^ADDR_W → ERROR.
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO.
  - DATA_LO → DATA_HI while words remain; after word N → CHK_HI or DONE.
  - CHK_HI → CHK_LO → DONE or ERROR.
  - DONE and ERROR are terminal until `reload` or `reset`.
- Word counter: width ADDR_W+1, compared against N. N = 2^ADDR_W is legal.
- Address: starts at 0 and increments by 1 after each write. The address wraps to 0 only after the final legal word, and no write occurs there.
- `in_ready` is 1 in HDR_*, DATA_*, CHK_*. It is 0 in DONE, ERROR, and on the cycle of an `imem_we` pulse.
- `reload`:
  - clears the address, counter, checksum, `cpu_run` and `load_err`;
  - returns the FSM to HDR_HI on the next edge;
  - takes priority over a simultaneous byte transfer (that byte is dropped).
- Bytes presented in DONE/ERROR are ignored; `in_ready` is 0 there.

## Timing
- Reset values:
  - `in_ready` = 0; it rises on the first clock edge after `reset` deasserts.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_run` = 0, `load_err` = 0.
  - FSM = HDR_HI.
- Write latency: `imem_we` pulses for exactly one cycle, on the cycle after the lo byte is accepted. `imem_addr`/`imem_wdata` are valid during that cycle and hold afterwards.
- Throughput: at most one byte per cycle, except for one bubble after each lo data byte (the write cycle).
- `cpu_run` rises on the cycle after the final `imem_we`. With N = 0 and no checksum, it rises on the cycle after the header lo byte. It stays high until `reload` or `reset`.
- `load_err` rises on the cycle after the offending byte is accepted. `cpu_run` never asserts in ERROR.
- Asserting `reset` mid-load immediately:
  - forces all outputs to their reset values;
  - abandons any partial word;
  - forces `imem_we` low asynchronously.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - a 16-bit running sum, modulo 2^16, is kept over the data words only;
  - a trailing checksum word is expected;
  - match → DONE, `cpu_run` = 1;
  - mismatch → ERROR, `load_err` = 1, `cpu_run` stays 0.
- `LOADER_CHECKSUM_EN` undefined:
  - no checksum states or adder;
  - DONE follows the last data word directly;
  - `load_err` is set only for N > 2^ADDR_W.

## Test plan
- Reset, then bytes 00 02 12 34 AB CD at one per cycle → writes 0x1234 @0 and 0xABCD @1, each `imem_we` one cycle wide; `cpu_run` rises the cycle after the second write.
- Header 00 00 → no writes; `cpu_run` = 1 (checksum build: after checksum 00 00).
- ADDR_W=8, header 01 01 → `load_err` = 1, `in_ready` = 0, no writes, `cpu_run` = 0.
- Checksum build: N=2, words 0x8000 and 0x8001, checksum 00 01 → DONE; with checksum 00 02 instead → ERROR.
- `reset` low after 3 data words of N=5 → outputs return to reset values. A fresh 00 01 55 AA then writes 0x55AA @0.
- `reload` in DONE, coincident with `in_valid` → that byte is dropped, `cpu_run` falls, and the next stream loads from address 0.
